// File: rtl/mem_copy_engine_if.sv
// Bus bundle between the block-move engine and its environment:
// start/parameter handshake plus the data memory mrd/mwr/adr/wdata/rdata port.
interface mem_copy_engine_if #(
    parameter int unsigned LEN_W = 16
);
    logic             start;
    logic [31:0]      src_adr;
    logic [31:0]      dst_adr;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             done;
    logic [31:0]      sum;
    logic [31:0]      adr;
    logic             mrd;
    logic             mwr;
    logic [31:0]      wdata;
    logic [31:0]      rdata;

    modport master (
        input  start, src_adr, dst_adr, len, rdata,
        output busy, done, sum, adr, mrd, mwr, wdata
    );

    modport slave (
        output start, src_adr, dst_adr, len, rdata,
        input  busy, done, sum, adr, mrd, mwr, wdata
    );
endinterface

// File: rtl/mem_copy_engine.sv
// Block-move engine: copies len 32-bit words from src to dst, one read then one
// write per word, accumulating a wrapping sum of the words moved.
module mem_copy_engine #(
    parameter int unsigned LEN_W      = 16,
    parameter int unsigned WORD_BYTES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_copy_engine_if.master  bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic [31:0]      STEP    = 32'(WORD_BYTES);
    localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [31:0]      src_ptr;
    logic [31:0]      dst_ptr;
    logic [31:0]      data_reg;
    logic [31:0]      sum_q;
    logic [LEN_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = (bus.len == '0) ? DONE : READ;
            READ:    state_nxt = WRITE;
            WRITE:   state_nxt = (cnt == CNT_ONE) ? DONE : READ;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory port is decoded from state alone so rdata can be captured in READ.
    always_comb begin
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        bus.adr   = '0;
        bus.mrd   = 1'b0;
        bus.mwr   = 1'b0;
        bus.wdata = '0;
        case (state)
            READ: begin
                bus.busy = 1'b1;
                bus.adr  = src_ptr;
                bus.mrd  = 1'b1;
            end
            WRITE: begin
                bus.busy  = 1'b1;
                bus.adr   = dst_ptr;
                bus.mwr   = 1'b1;
                bus.wdata = data_reg;
            end
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            src_ptr  <= '0;
            dst_ptr  <= '0;
            data_reg <= '0;
            sum_q    <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sum_q <= '0;
                        if (bus.len != '0) begin
                            src_ptr <= bus.src_adr;
                            dst_ptr <= bus.dst_adr;
                            cnt     <= bus.len;
                        end
                    end
                end
                READ: begin
                    data_reg <= bus.rdata;
                    sum_q    <= sum_q + bus.rdata;
                    src_ptr  <= src_ptr + STEP;
                end
                WRITE: begin
                    dst_ptr <= dst_ptr + STEP;
                    cnt     <= cnt - CNT_ONE;
                end
                default: ;
            endcase
        end
    end

    assign bus.sum = sum_q;
endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine with a 256-word behavioural data memory.
module tb_mem_copy_engine;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_copy_engine_if #(.LEN_W(16)) bus ();

    mem_copy_engine #(.LEN_W(16), .WORD_BYTES(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    logic [31:0] mem [0:255];
    logic        ld_en;
    logic [7:0]  ld_idx;
    logic [31:0] ld_data;

    assign bus.rdata = mem[bus.adr[9:2]];

    always @(posedge clk) begin
        if (bus.mwr)     mem[bus.adr[9:2]] <= bus.wdata;
        else if (ld_en)  mem[ld_idx]       <= ld_data;
    end

    int n_cmp = 0;
    int n_err = 0;

    int done_cyc, done_cnt, busy_cnt, busy_first, busy_last, mem_acc, both_cnt;
    logic [31:0] rd_log [$];
    logic [3:0]  pr_ctl;
    logic [31:0] pr_adr, pr_wdata, pr_sum;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [31:0] a, input logic [31:0] v);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_idx  = a[9:2];
        ld_data = v;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    function automatic logic [31:0] peek(input logic [31:0] a);
        return mem[a[9:2]];
    endfunction

    // Cycle c counts from the edge that accepts start; pa/pb pulse start in
    // cycle c, ra drops rst_n in cycle c (0 = unused).
    task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                            input int pa, input int pb, input int ra, input int ncyc);
        done_cyc = 0; done_cnt = 0; busy_cnt = 0; busy_first = 0; busy_last = 0;
        mem_acc = 0; both_cnt = 0; rd_log.delete();
        @(negedge clk);
        bus.start = 1'b1; bus.src_adr = s; bus.dst_adr = d; bus.len = n;
        @(posedge clk);
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (bus.busy) begin
                busy_cnt++;
                if (busy_first == 0) busy_first = c;
                busy_last = c;
            end
            if (bus.done) begin done_cnt++; done_cyc = c; end
            if (bus.mrd || bus.mwr) mem_acc++;
            if (bus.mrd && bus.mwr) both_cnt++;
            if (bus.mrd) rd_log.push_back(bus.adr);
            if (c == ra + 1) begin
                pr_ctl = {bus.busy, bus.done, bus.mrd, bus.mwr};
                pr_adr = bus.adr; pr_wdata = bus.wdata; pr_sum = bus.sum;
            end
            if (c == 1) begin
                bus.src_adr = 32'h0000_0FF0; bus.dst_adr = 32'h0; bus.len = 16'hFFFF;
            end
            bus.start = (c == pa) || (c == pb);
            rst_n     = (c != ra);
        end
    endtask

    task automatic fill_src_dst();
        for (int i = 0; i < 6; i++) begin
            poke(32'(100 + 4 * i), 32'(i));
            poke(32'(200 + 4 * i), 32'hA5A5_0000 | 32'(i));
        end
    endtask

    initial begin
        rst_n = 1'b0; bus.start = 1'b0; bus.src_adr = '0; bus.dst_adr = '0; bus.len = '0;
        ld_en = 1'b0; ld_idx = '0; ld_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ctl", {28'h0, bus.busy, bus.done, bus.mrd, bus.mwr}, 32'h0);
        check("rst_adr", bus.adr, 32'h0);
        check("rst_wdata", bus.wdata, 32'h0);
        check("rst_sum", bus.sum, 32'h0);
        rst_n = 1'b1;

        // Basic copy of six words
        fill_src_dst();
        run_copy(32'd100, 32'd200, 16'd6, 0, 0, 0, 16);
        check("t1_done_cyc", done_cyc, 32'd13);
        check("t1_done_cnt", done_cnt, 32'd1);
        check("t1_busy_cnt", busy_cnt, 32'd12);
        check("t1_busy_first", busy_first, 32'd1);
        check("t1_busy_last", busy_last, 32'd12);
        check("t1_rd_wr_overlap", both_cnt, 32'd0);
        check("t1_sum", bus.sum, 32'd15);
        check("t1_rd_count", rd_log.size(), 32'd6);
        check("t1_rd0_adr", (rd_log.size() > 0) ? rd_log[0] : 32'hFFFF_FFFF, 32'd100);
        for (int i = 0; i < 6; i++) check($sformatf("t1_mem%0d", i), peek(32'(200 + 4 * i)), 32'(i));

        // Zero length
        run_copy(32'd100, 32'd200, 16'd0, 0, 0, 0, 4);
        check("t2_done_cyc", done_cyc, 32'd1);
        check("t2_done_cnt", done_cnt, 32'd1);
        check("t2_mem_acc", mem_acc, 32'd0);
        check("t2_busy_cnt", busy_cnt, 32'd0);
        check("t2_sum", bus.sum, 32'd0);

        // start pulsed while busy and while in DONE
        fill_src_dst();
        run_copy(32'd100, 32'd200, 16'd6, 4, 13, 0, 18);
        check("t3_done_cnt", done_cnt, 32'd1);
        check("t3_done_cyc", done_cyc, 32'd13);
        check("t3_busy_cnt", busy_cnt, 32'd12);
        check("t3_sum", bus.sum, 32'd15);
        for (int i = 0; i < 6; i++) check($sformatf("t3_mem%0d", i), peek(32'(200 + 4 * i)), 32'(i));

        // Reset during cycle 5 of the copy
        fill_src_dst();
        run_copy(32'd100, 32'd200, 16'd6, 0, 0, 5, 16);
        check("t4_ctl", {28'h0, pr_ctl}, 32'h0);
        check("t4_adr", pr_adr, 32'h0);
        check("t4_wdata", pr_wdata, 32'h0);
        check("t4_sum", pr_sum, 32'h0);
        check("t4_done_cnt", done_cnt, 32'd0);
        check("t4_busy_cnt", busy_cnt, 32'd5);
        check("t4_mem0", peek(32'd200), 32'd0);
        check("t4_mem1", peek(32'd204), 32'd1);
        check("t4_mem2", peek(32'd208), 32'hA5A5_0002);
        check("t4_mem3", peek(32'd212), 32'hA5A5_0003);

        // Overlapping forward copy replicates the first word
        poke(32'd100, 32'd7); poke(32'd104, 32'd8); poke(32'd108, 32'd9); poke(32'd112, 32'hEE);
        run_copy(32'd100, 32'd104, 16'd3, 0, 0, 0, 10);
        check("t5_sum", bus.sum, 32'd21);
        check("t5_done_cyc", done_cyc, 32'd7);
        for (int i = 0; i < 4; i++) check($sformatf("t5_mem%0d", i), peek(32'(100 + 4 * i)), 32'd7);

        // Address and sum wrap
        poke(32'hFFFF_FFFC, 32'hFFFF_FFFF); poke(32'h0, 32'd2);
        poke(32'd300, 32'h0); poke(32'd304, 32'h0);
        run_copy(32'hFFFF_FFFC, 32'd300, 16'd2, 0, 0, 0, 8);
        check("t6_sum", bus.sum, 32'h0000_0001);
        check("t6_done_cyc", done_cyc, 32'd5);
        check("t6_rd_count", rd_log.size(), 32'd2);
        check("t6_rd0_adr", (rd_log.size() > 0) ? rd_log[0] : 32'h1234_5678, 32'hFFFF_FFFC);
        check("t6_rd1_adr", (rd_log.size() > 1) ? rd_log[1] : 32'h1234_5678, 32'h0000_0000);
        check("t6_mem0", peek(32'd300), 32'hFFFF_FFFF);
        check("t6_mem1", peek(32'd304), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
